// File: rtl/binary_to_bcd_if.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_if
// Start/done handshake bundle for the binary_to_bcd converter.
//   start    : request a conversion of bin (taken only while busy=0)
//   bin      : 14-bit unsigned value, sampled on the accepting edge
//   busy     : conversion in progress
//   done     : one-cycle pulse, bcd/overflow just updated
//   bcd      : packed 4-digit BCD result (thousands in [15:12])
//   overflow : value at acceptance was above 9999
// Modports: master issues requests, slave is the converter.
// -----------------------------------------------------------------------------
interface binary_to_bcd_if;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output overflow
    );
endinterface

// File: rtl/binary_to_bcd.sv
// -----------------------------------------------------------------------------
// binary_to_bcd
// Sequential 14-bit binary to 4-digit packed BCD converter (double-dabble,
// one bit per clock). A conversion takes 14 shift cycles after the accepting
// edge; done pulses for one cycle when bcd/overflow are updated.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : binary_to_bcd_if.slave (start, bin, busy, done, bcd, overflow)
// Build option:
//   BCD_SATURATE_EN - when defined, an overflowing input reports 16'h9999
//                     instead of the raw (bin mod 10000) digits.
// -----------------------------------------------------------------------------
module binary_to_bcd (
    input  logic             clk,
    input  logic             rst_n,
    binary_to_bcd_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [13:0] bin_q;        // captured copy of bin, consumed MSB first
    logic [15:0] scratch_q;    // BCD digits being built
    logic [3:0]  cnt_q;        // bits left to consume
    logic        ovf_pend_q;   // overflow of the value in flight
    logic [15:0] bcd_q;
    logic        ovf_q;
    logic        done_q;

    logic        load;
    logic        step;
    logic        finish;
    logic [15:0] adj;
    logic [29:0] shifted;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

`ifdef BCD_SATURATE_EN
    function automatic logic [15:0] sat_bcd(input logic [15:0] raw, input logic ovf);
        return ovf ? 16'h9999 : raw;
    endfunction
`endif

    // Add-3 on the pre-shift digits, then shift {scratch, bin} left by one.
    // Whatever leaves the thousands digit falls off the top, so the result
    // is bin mod 10000.
    always_comb begin
        adj     = {add3(scratch_q[15:12]), add3(scratch_q[11:8]),
                   add3(scratch_q[7:4]),   add3(scratch_q[3:0])};
        shifted = {adj, bin_q} << 1;
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state and control ----
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == 4'd1) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- Datapath and result registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                bin_q      <= bus.bin;
                scratch_q  <= '0;
                cnt_q      <= 4'd14;
                ovf_pend_q <= (bus.bin > 14'd9999);
            end else if (step) begin
                scratch_q <= shifted[29:14];
                bin_q     <= shifted[13:0];
                cnt_q     <= cnt_q - 4'd1;
            end
            if (finish) begin
`ifdef BCD_SATURATE_EN
                bcd_q <= sat_bcd(shifted[29:14], ovf_pend_q);
`else
                bcd_q <= shifted[29:14];
`endif
                ovf_q <= ovf_pend_q;
            end
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_binary_to_bcd
// Directed bench for binary_to_bcd. Expected results come from an arithmetic
// decimal model, are queued when a conversion is accepted and are checked
// when done pulses.
// -----------------------------------------------------------------------------
module tb_binary_to_bcd;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    binary_to_bcd_if bus ();

    binary_to_bcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          val;
    } exp_t;

    exp_t        sb[$];
    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    logic [15:0] held_bcd = 16'h0000;
    logic        held_ovf = 1'b0;
    logic        done_prev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_bcd(input int v);
        int          m;
        logic [15:0] r;
        m = v % 10000;
        r = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
`ifdef BCD_SATURATE_EN
        if (v > 9999) r = 16'h9999;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued request.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            done_cnt++;
            chk("done_width", {31'd0, done_prev}, 32'd0);
            chk("done_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("bcd_%0d", e.val), {16'd0, bus.bcd}, {16'd0, e.bcd});
                chk($sformatf("ovf_%0d", e.val), {31'd0, bus.overflow}, {31'd0, e.ovf});
                held_bcd = e.bcd;
                held_ovf = e.ovf;
            end
        end
        done_prev <= bus.done;
    end

    task automatic start_conv(input int v, input bit keep, input bit push, output int t0);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'(v);
        @(posedge clk);
        #1;
        t0 = cyc;
        chk($sformatf("busy_after_accept_%0d", v), {31'd0, bus.busy}, 32'd1);
        chk($sformatf("bcd_hold_%0d", v), {16'd0, bus.bcd}, {16'd0, held_bcd});
        if (push) begin
            e.bcd = model_bcd(v);
            e.ovf = (v > 9999);
            e.val = v;
            sb.push_back(e);
        end
        if (!keep) bus.start = 1'b0;
    endtask

    task automatic wait_done(input int t0, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, cyc - t0, 32'd14);
            chk({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
        end
    endtask

    task automatic convert(input int v);
        int t0;
        start_conv(v, 1'b0, 1'b1, t0);
        wait_done(t0, $sformatf("conv_%0d", v));
        @(negedge clk);
        chk($sformatf("done_low_after_%0d", v), {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int t0;
        int d0;
        exp_t e;

        // Reset held with a pending request.
        rst_n     = 1'b1;
        bus.start = 1'b1;
        bus.bin   = 14'd1023;
        #2 rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bcd",  {16'd0, bus.bcd},      32'h0);
        chk("rst_done", {31'd0, bus.done},     32'd0);
        chk("rst_busy", {31'd0, bus.busy},     32'd0);
        chk("rst_ovf",  {31'd0, bus.overflow}, 32'd0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_after_rst_done", {31'd0, done_cnt}, 32'd0);

        // Basic and carry-heavy values.
        convert(0);
        convert(10);
        convert(31);
        convert(153);
        convert(1023);
        convert(2730);
        convert(9999);

        // start held and bin changed while busy; back-to-back start in done cycle.
        start_conv(201, 1'b1, 1'b1, t0);
        @(negedge clk);
        bus.bin = 14'd500;
        wait_done(t0, "hs_201");
        bus.bin = 14'd42;
        @(posedge clk);
        #1;
        t0 = cyc;
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b_bcd_hold", {16'd0, bus.bcd}, {16'd0, held_bcd});
        e.bcd = model_bcd(42);
        e.ovf = 1'b0;
        e.val = 42;
        sb.push_back(e);
        bus.start = 1'b0;
        wait_done(t0, "b2b_42");
        @(negedge clk);
        chk("b2b_done_low", {31'd0, bus.done}, 32'd0);

        // Overflow cases.
        convert(12345);
        convert(16383);
        chk("ovf_16383_bcd_value", {16'd0, held_bcd}, model_bcd(16383));

        // Reset after 7 shift cycles: outputs cleared, no done.
        start_conv(777, 1'b0, 1'b0, t0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_bcd",  {16'd0, bus.bcd},      32'h0);
        chk("midrst_busy", {31'd0, bus.busy},     32'd0);
        chk("midrst_done", {31'd0, bus.done},     32'd0);
        chk("midrst_ovf",  {31'd0, bus.overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        held_bcd = 16'h0000;
        held_ovf = 1'b0;
        d0       = done_cnt;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort", done_cnt, d0);
        convert(8);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
